// File: rtl/wb_arbiter_pkg.sv
// Shared widths, write-back entry payload and pending-mask decode helper.
package wb_arbiter_pkg;

  localparam int unsigned ARCH_BITS        = 32;
  localparam int unsigned REG_IDX_BITS     = 5;
  localparam int unsigned NUM_REGS         = 32;
  localparam int unsigned NUM_SPECIAL_REGS = 5;
  localparam int unsigned MASK_BITS        = NUM_REGS + NUM_SPECIAL_REGS;
  localparam int unsigned MASK_IDX_BITS    = $clog2(MASK_BITS);
  localparam int unsigned WB_DEPTH         = 4;

  // One queued register write: special selects the rmN bank.
  typedef struct packed {
    logic                    special;
    logic [REG_IDX_BITS-1:0] dst;
    logic [ARCH_BITS-1:0]    data;
  } wb_entry_t;

  localparam int unsigned ENTRY_BITS = $bits(wb_entry_t);

  // One-hot hazard bit for an entry; out-of-range special indices map to nothing.
  function automatic logic [MASK_BITS-1:0] wb_mask_bit(input wb_entry_t e);
    logic [MASK_IDX_BITS-1:0] idx;
    logic [MASK_BITS-1:0]     m;
    if (e.special) begin
      idx = MASK_IDX_BITS'(NUM_REGS) + MASK_IDX_BITS'(e.dst);
      m   = (32'(e.dst) < NUM_SPECIAL_REGS) ? (MASK_BITS'(1) << idx) : '0;
    end else begin
      idx = MASK_IDX_BITS'(e.dst);
      m   = MASK_BITS'(1) << idx;
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Producer handshakes plus register-file port A and hazard/status outputs.
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic                    aluValid;
  logic                    aluReady;
  logic [REG_IDX_BITS-1:0] aluDst;
  logic                    aluSpecial;
  logic [ARCH_BITS-1:0]    aluData;

  logic                    memValid;
  logic                    memReady;
  logic [REG_IDX_BITS-1:0] memDst;
  logic                    memSpecial;
  logic [ARCH_BITS-1:0]    memData;

  logic                    mulValid;
  logic                    mulReady;
  logic [REG_IDX_BITS-1:0] mulDst;
  logic                    mulSpecial;
  logic [ARCH_BITS-1:0]    mulData;

  logic                    wbHold;

  logic [REG_IDX_BITS-1:0] dst;
  logic                    specialDst;
  logic [ARCH_BITS-1:0]    wData;
  logic                    writeEnable;
  logic [MASK_BITS-1:0]    pendingMask;
  logic                    full;
  logic                    empty;

  modport slave (
    input  aluValid, aluDst, aluSpecial, aluData,
    input  memValid, memDst, memSpecial, memData,
    input  mulValid, mulDst, mulSpecial, mulData,
    input  wbHold,
    output aluReady, memReady, mulReady,
    output dst, specialDst, wData, writeEnable, pendingMask, full, empty
  );

  modport master (
    output aluValid, aluDst, aluSpecial, aluData,
    output memValid, memDst, memSpecial, memData,
    output mulValid, mulDst, mulSpecial, mulData,
    output wbHold,
    input  aluReady, memReady, mulReady,
    input  dst, specialDst, wData, writeEnable, pendingMask, full, empty
  );

endinterface

// File: rtl/wb_fifo.sv
// Parametric in-order sync FIFO exposing per-slot valid bits and contents.
module wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_push,
  input  logic [WIDTH-1:0]            i_data,
  input  logic                        i_pop,
  output logic [WIDTH-1:0]            o_head_c,
  output logic [DEPTH-1:0][WIDTH-1:0] o_entries,
  output logic [DEPTH-1:0]            o_valid,
  output logic                        o_full,
  output logic                        o_empty
);

  localparam int unsigned PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_BITS = PTR_BITS + 1;

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [PTR_BITS-1:0]         r_wr_ptr;
  logic [PTR_BITS-1:0]         r_rd_ptr;
  logic [CNT_BITS-1:0]         r_count;
  logic [CNT_BITS-1:0]         w_count_nxt;
  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0]            w_valid_nxt;
  logic                        r_full;
  logic                        r_empty;

  // Next occupancy; a pop frees the head slot before a same-cycle push refills it.
  always_comb begin
    w_count_nxt = r_count;
    w_valid_nxt = r_valid;
    if (i_push && !i_pop) begin
      w_count_nxt = r_count + CNT_BITS'(1);
    end else if (!i_push && i_pop) begin
      w_count_nxt = r_count - CNT_BITS'(1);
    end
    if (i_pop) begin
      w_valid_nxt[r_rd_ptr] = 1'b0;
    end
    if (i_push) begin
      w_valid_nxt[r_wr_ptr] = 1'b1;
    end
  end

  // Pointers, count, valid vector and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
      end
      r_count <= w_count_nxt;
      r_valid <= w_valid_nxt;
      r_full  <= (w_count_nxt == CNT_BITS'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Entry storage; contents are qualified by r_valid so no reset is needed.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_head_c  = r_mem[r_rd_ptr];
  assign o_entries = r_mem;
  assign o_valid   = r_valid;
  assign o_full    = r_full;
  assign o_empty   = r_empty;

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: MEM > MUL > ALU grant into a FIFO, one register write per cycle.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH
) (
  input logic         clk,
  input logic         rst_n,
  wb_arbiter_if.slave bus
);

  localparam int unsigned PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                             w_fifo_full;
  logic                             w_fifo_empty;
  logic                             w_pop;
  logic                             w_push;
  logic                             w_can_push;
  logic                             w_grant_mem;
  logic                             w_grant_mul;
  logic                             w_grant_alu;
  wb_entry_t                        w_push_entry;
  wb_entry_t                        w_head;
  logic [ENTRY_BITS-1:0]            w_head_bits;
  logic [DEPTH-1:0][ENTRY_BITS-1:0] w_entries;
  logic [DEPTH-1:0]                 w_valid;
  logic [MASK_BITS-1:0]             w_mask;
  logic                             r_we;
  wb_entry_t                        r_out;

  // Fixed-priority grant; a push is allowed when a slot is free or freed this cycle.
  always_comb begin
    w_pop        = !bus.wbHold && !w_fifo_empty;
    w_can_push   = rst_n && (!w_fifo_full || w_pop);
    w_grant_mem  = bus.memValid;
    w_grant_mul  = !bus.memValid && bus.mulValid;
    w_grant_alu  = !bus.memValid && !bus.mulValid && bus.aluValid;
    w_push       = w_can_push && (w_grant_mem || w_grant_mul || w_grant_alu);
    w_push_entry = '{special: bus.aluSpecial, dst: bus.aluDst, data: bus.aluData};
    if (w_grant_mem) begin
      w_push_entry = '{special: bus.memSpecial, dst: bus.memDst, data: bus.memData};
    end else if (w_grant_mul) begin
      w_push_entry = '{special: bus.mulSpecial, dst: bus.mulDst, data: bus.mulData};
    end
  end

  assign bus.memReady = w_can_push && w_grant_mem;
  assign bus.mulReady = w_can_push && w_grant_mul;
  assign bus.aluReady = w_can_push && w_grant_alu;

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_data    (w_push_entry),
    .i_pop     (w_pop),
    .o_head_c  (w_head_bits),
    .o_entries (w_entries),
    .o_valid   (w_valid),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  assign w_head = wb_entry_t'(w_head_bits);

  // Register-file port A: pop head into output regs, pulse writeEnable for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we  <= 1'b0;
      r_out <= '0;
    end else begin
      r_we <= w_pop;
      if (w_pop) begin
        r_out <= w_head;
      end
    end
  end

  // Hazard mask: every valid queued entry plus the write currently issuing.
  always_comb begin
    w_mask = r_we ? wb_mask_bit(r_out) : '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_valid[PTR_BITS'(i)]) begin
        w_mask = w_mask | wb_mask_bit(wb_entry_t'(w_entries[PTR_BITS'(i)]));
      end
    end
  end

  assign bus.dst         = r_out.dst;
  assign bus.specialDst  = r_out.special;
  assign bus.wData       = r_out.data;
  assign bus.writeEnable = r_we;
  assign bus.pendingMask = w_mask;
  assign bus.full        = w_fifo_full;
  assign bus.empty       = w_fifo_empty;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboarded bench for wb_arbiter: commits are checked in acceptance order.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;
  localparam int SRC_MUL = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  wb_entry_t sb[$];

  always #5 clk = ~clk;

  wb_arbiter_if bus ();

  wb_arbiter #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic wb_entry_t mk(input logic sp, input logic [REG_IDX_BITS-1:0] d,
                                   input logic [ARCH_BITS-1:0] x);
    wb_entry_t e;
    e.special = sp;
    e.dst     = d;
    e.data    = x;
    return e;
  endfunction

  function automatic logic [MASK_BITS-1:0] bit_of(input int n);
    return MASK_BITS'(1) << n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int src, input logic v, input logic sp,
                       input logic [REG_IDX_BITS-1:0] d, input logic [ARCH_BITS-1:0] x);
    case (src)
      SRC_MEM: begin bus.memValid = v; bus.memSpecial = sp; bus.memDst = d; bus.memData = x; end
      SRC_MUL: begin bus.mulValid = v; bus.mulSpecial = sp; bus.mulDst = d; bus.mulData = x; end
      default: begin bus.aluValid = v; bus.aluSpecial = sp; bus.aluDst = d; bus.aluData = x; end
    endcase
  endtask

  task automatic idle_all();
    drive(SRC_ALU, 1'b0, 1'b0, '0, '0);
    drive(SRC_MEM, 1'b0, 1'b0, '0, '0);
    drive(SRC_MUL, 1'b0, 1'b0, '0, '0);
  endtask

  // Commit monitor: every writeEnable cycle must match the oldest expected entry.
  always @(negedge clk) begin : monitor
    wb_entry_t exp_e;
    if (rst_n && bus.writeEnable) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected: got sp=%0b dst=%0d data=%h, none expected",
                 bus.specialDst, bus.dst, bus.wData);
      end else begin
        exp_e = sb.pop_front();
        if ({bus.specialDst, bus.dst, bus.wData} !== exp_e) begin
          errors++;
          $display("FAIL commit_order: got sp=%0b dst=%0d data=%h want sp=%0b dst=%0d data=%h",
                   bus.specialDst, bus.dst, bus.wData, exp_e.special, exp_e.dst, exp_e.data);
        end
      end
    end
  end

  task automatic test_reset();
    idle_all();
    bus.wbHold = 1'b0;
    #2 rst_n = 1'b0;
    bus.aluValid = 1'b1;
    #1;
    checks++;
    if ({bus.aluReady, bus.writeEnable, bus.empty, bus.full} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_status: got rdy/we/empty/full=%b want 0010",
               {bus.aluReady, bus.writeEnable, bus.empty, bus.full});
    end
    checks++;
    if ({bus.pendingMask, bus.specialDst, bus.dst, bus.wData} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got mask=%h dst=%0d data=%h want zeros",
               bus.pendingMask, bus.dst, bus.wData);
    end
    idle_all();
    tick();
    rst_n = 1'b1;
    tick();
    // Queue three writes under hold, start issuing, then reset mid-burst.
    bus.wbHold = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      drive(SRC_ALU, 1'b1, 1'b0, REG_IDX_BITS'(k), ARCH_BITS'(32'h50 + k));
      #1;
      checks++;
      if (bus.aluReady !== 1'b1) begin
        errors++;
        $display("FAIL reset_fill_ready: got %b want 1 (k=%0d)", bus.aluReady, k);
      end
      sb.push_back(mk(1'b0, REG_IDX_BITS'(k), ARCH_BITS'(32'h50 + k)));
      tick();
    end
    idle_all();
    checks++;
    if (bus.pendingMask !== (bit_of(1) | bit_of(2) | bit_of(3))) begin
      errors++;
      $display("FAIL reset_fill_mask: got %h want %h", bus.pendingMask,
               bit_of(1) | bit_of(2) | bit_of(3));
    end
    bus.wbHold = 1'b0;
    tick();
    rst_n = 1'b0;
    bus.aluValid = 1'b1;
    #1;
    checks++;
    if ({bus.writeEnable, bus.aluReady, bus.empty} !== 3'b001 || bus.pendingMask !== '0) begin
      errors++;
      $display("FAIL reset_midburst: got we/rdy/empty=%b mask=%h want 001 mask=0",
               {bus.writeEnable, bus.aluReady, bus.empty}, bus.pendingMask);
    end
    sb.delete();
    idle_all();
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({bus.writeEnable, bus.empty} !== 2'b01 || bus.pendingMask !== '0) begin
        errors++;
        $display("FAIL reset_after: got we/empty=%b mask=%h want 01 mask=0 (cyc %0d)",
                 {bus.writeEnable, bus.empty}, bus.pendingMask, k);
      end
    end
  endtask

  task automatic test_single();
    drive(SRC_ALU, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF);
    #1;
    checks++;
    if ({bus.memReady, bus.mulReady, bus.aluReady} !== 3'b001) begin
      errors++;
      $display("FAIL single_ready: got %b want 001", {bus.memReady, bus.mulReady, bus.aluReady});
    end
    sb.push_back(mk(1'b0, 5'd5, 32'hDEADBEEF));
    tick();
    idle_all();
    checks++;
    if (bus.writeEnable !== 1'b0 || bus.pendingMask !== bit_of(5)) begin
      errors++;
      $display("FAIL single_queued: got we=%b mask=%h want we=0 mask=%h",
               bus.writeEnable, bus.pendingMask, bit_of(5));
    end
    tick();
    checks++;
    if ({bus.writeEnable, bus.specialDst, bus.dst, bus.wData} !== {1'b1, 1'b0, 5'd5, 32'hDEADBEEF}
        || bus.pendingMask !== bit_of(5)) begin
      errors++;
      $display("FAIL single_issue: got we=%b sp=%b dst=%0d data=%h mask=%h",
               bus.writeEnable, bus.specialDst, bus.dst, bus.wData, bus.pendingMask);
    end
    tick();
    checks++;
    if (bus.writeEnable !== 1'b0 || bus.pendingMask !== '0 || bus.dst !== 5'd5
        || bus.wData !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_after: got we=%b mask=%h dst=%0d data=%h want 0/0/5/deadbeef",
               bus.writeEnable, bus.pendingMask, bus.dst, bus.wData);
    end
  endtask

  task automatic test_priority();
    logic [2:0] want_rdy [3];
    int         src_of   [3];
    want_rdy[0] = 3'b100; want_rdy[1] = 3'b010; want_rdy[2] = 3'b001;
    src_of[0]   = SRC_MEM; src_of[1] = SRC_MUL; src_of[2] = SRC_ALU;
    drive(SRC_MEM, 1'b1, 1'b0, 5'd10, 32'h0000_000A);
    drive(SRC_MUL, 1'b1, 1'b0, 5'd11, 32'h0000_000B);
    drive(SRC_ALU, 1'b1, 1'b0, 5'd12, 32'h0000_000C);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({bus.memReady, bus.mulReady, bus.aluReady} !== want_rdy[k]) begin
        errors++;
        $display("FAIL prio_ready: got %b want %b (step %0d)",
                 {bus.memReady, bus.mulReady, bus.aluReady}, want_rdy[k], k);
      end
      sb.push_back(mk(1'b0, REG_IDX_BITS'(10 + k), ARCH_BITS'(32'hA + k)));
      tick();
      drive(src_of[k], 1'b0, 1'b0, '0, '0);
    end
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (sb.size() != 0 || bus.empty !== 1'b1 || bus.pendingMask !== '0) begin
      errors++;
      $display("FAIL prio_drain: got left=%0d empty=%b mask=%h want 0/1/0",
               sb.size(), bus.empty, bus.pendingMask);
    end
  endtask

  task automatic test_full();
    bus.wbHold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(SRC_ALU, 1'b1, 1'b0, REG_IDX_BITS'(16 + k), ARCH_BITS'(32'h100 + k));
      #1;
      checks++;
      if (bus.aluReady !== 1'b1) begin
        errors++;
        $display("FAIL full_fill_ready: got %b want 1 (k=%0d)", bus.aluReady, k);
      end
      sb.push_back(mk(1'b0, REG_IDX_BITS'(16 + k), ARCH_BITS'(32'h100 + k)));
      tick();
    end
    drive(SRC_ALU, 1'b1, 1'b0, 5'd20, 32'h104);
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({bus.aluReady, bus.full, bus.writeEnable} !== 3'b010) begin
        errors++;
        $display("FAIL full_blocked: got rdy/full/we=%b want 010 (cyc %0d)",
                 {bus.aluReady, bus.full, bus.writeEnable}, k);
      end
      tick();
    end
    bus.wbHold = 1'b0;
    #1;
    checks++;
    if (bus.aluReady !== 1'b1) begin
      errors++;
      $display("FAIL full_push_on_pop: got %b want 1", bus.aluReady);
    end
    sb.push_back(mk(1'b0, 5'd20, 32'h104));
    tick();
    idle_all();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.writeEnable !== 1'b1) begin
        errors++;
        $display("FAIL full_drain_we: got %b want 1 (cyc %0d)", bus.writeEnable, k);
      end
      if (k == 1) begin
        checks++;
        if (bus.full !== 1'b0) begin
          errors++;
          $display("FAIL full_clear: got %b want 0", bus.full);
        end
      end
      tick();
    end
    checks++;
    if ({bus.writeEnable, bus.empty} !== 2'b01) begin
      errors++;
      $display("FAIL full_done: got we/empty=%b want 01", {bus.writeEnable, bus.empty});
    end
  endtask

  task automatic test_hold_inflight();
    drive(SRC_MEM, 1'b1, 1'b0, 5'd7, 32'h7);
    #1;
    sb.push_back(mk(1'b0, 5'd7, 32'h7));
    tick();
    drive(SRC_MEM, 1'b1, 1'b0, 5'd8, 32'h8);
    #1;
    sb.push_back(mk(1'b0, 5'd8, 32'h8));
    tick();
    idle_all();
    bus.wbHold = 1'b1;
    checks++;
    if ({bus.writeEnable, bus.dst} !== {1'b1, 5'd7}) begin
      errors++;
      $display("FAIL hold_inflight: got we=%b dst=%0d want 1/7", bus.writeEnable, bus.dst);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (bus.writeEnable !== 1'b0 || bus.pendingMask !== bit_of(8)) begin
        errors++;
        $display("FAIL hold_wait: got we=%b mask=%h want 0/%h (cyc %0d)",
                 bus.writeEnable, bus.pendingMask, bit_of(8), k);
      end
    end
    bus.wbHold = 1'b0;
    tick();
    checks++;
    if ({bus.writeEnable, bus.dst} !== {1'b1, 5'd8}) begin
      errors++;
      $display("FAIL hold_resume: got we=%b dst=%0d want 1/8", bus.writeEnable, bus.dst);
    end
    tick();
  endtask

  task automatic test_special();
    drive(SRC_ALU, 1'b1, 1'b1, 5'd4, 32'h1);
    #1;
    sb.push_back(mk(1'b1, 5'd4, 32'h1));
    tick();
    idle_all();
    checks++;
    if (bus.pendingMask !== bit_of(36)) begin
      errors++;
      $display("FAIL special_queued_mask: got %h want %h", bus.pendingMask, bit_of(36));
    end
    tick();
    checks++;
    if ({bus.writeEnable, bus.specialDst, bus.dst} !== {1'b1, 1'b1, 5'd4}
        || bus.pendingMask !== bit_of(36)) begin
      errors++;
      $display("FAIL special_issue: got we=%b sp=%b dst=%0d mask=%h",
               bus.writeEnable, bus.specialDst, bus.dst, bus.pendingMask);
    end
    tick();
    checks++;
    if (bus.pendingMask !== '0) begin
      errors++;
      $display("FAIL special_clear: got %h want 0", bus.pendingMask);
    end
    drive(SRC_MUL, 1'b1, 1'b1, 5'd6, 32'h66);
    #1;
    sb.push_back(mk(1'b1, 5'd6, 32'h66));
    tick();
    idle_all();
    checks++;
    if (bus.pendingMask !== '0 || bus.empty !== 1'b0) begin
      errors++;
      $display("FAIL special_oob_queued: got mask=%h empty=%b want 0/0", bus.pendingMask, bus.empty);
    end
    tick();
    checks++;
    if ({bus.writeEnable, bus.specialDst, bus.dst} !== {1'b1, 1'b1, 5'd6} || bus.pendingMask !== '0) begin
      errors++;
      $display("FAIL special_oob_issue: got we=%b sp=%b dst=%0d mask=%h",
               bus.writeEnable, bus.specialDst, bus.dst, bus.pendingMask);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(SRC_MEM, 1'b1, 1'b0, 5'd3, 32'h1);
    #1;
    sb.push_back(mk(1'b0, 5'd3, 32'h1));
    tick();
    drive(SRC_MEM, 1'b1, 1'b0, 5'd3, 32'h2);
    #1;
    checks++;
    if (bus.memReady !== 1'b1 || bus.pendingMask !== bit_of(3)) begin
      errors++;
      $display("FAIL b2b_second_ready: got rdy=%b mask=%h", bus.memReady, bus.pendingMask);
    end
    sb.push_back(mk(1'b0, 5'd3, 32'h2));
    tick();
    idle_all();
    for (int k = 1; k <= 2; k++) begin
      checks++;
      if ({bus.writeEnable, bus.wData} !== {1'b1, ARCH_BITS'(k)} || bus.pendingMask !== bit_of(3)) begin
        errors++;
        $display("FAIL b2b_issue: got we=%b data=%h mask=%h want 1/%0d/%h",
                 bus.writeEnable, bus.wData, bus.pendingMask, k, bit_of(3));
      end
      tick();
    end
    checks++;
    if (bus.writeEnable !== 1'b0 || bus.pendingMask !== '0) begin
      errors++;
      $display("FAIL b2b_done: got we=%b mask=%h want 0/0", bus.writeEnable, bus.pendingMask);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_full();
    test_hold_inflight();
    test_special();
    test_back_to_back();
    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
